// File: rtl/slave_shared_pkg.sv
// Shared definitions for the SPI slave front-end: FSM state encoding,
// frame opcode constants and a helper that derives the captured frame width.
package slave_shared_pkg;

  // Slave FSM states, shared with the downstream controller
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } STATE_e;

  // Two leading opcode bits of every captured frame
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // A frame is the payload plus the two opcode bits in front of it
  function automatic int frameWidth(input int payloadW);
    return payloadW + 2;
  endfunction

endpackage

// File: rtl/spi_slave_param_tx_shifter.sv
// MSB-first parallel-to-serial shifter for SPI read data.
// A load strobe captures the word and drives its MSB immediately; each later
// enabled cycle drives the next bit, and one extra cycle returns the output
// to 0 and raises the sticky done flag. Clear has priority over load/shift.
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shiftEn,
  output logic              o_sout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_lastBit
);

  localparam int BCNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_shreg;
  logic [BCNT_W-1:0] r_bitCnt;
  logic              r_sout;
  logic              r_busy;
  logic              r_done;
  logic              w_allDriven;

  // All DATA_W bits have been put on the line; the next shift idles the output
  assign w_allDriven = (r_bitCnt == BCNT_W'(DATA_W));

  // Load, shift and completion tracking for the serial output bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg  <= '0;
      r_bitCnt <= '0;
      r_sout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_clear) begin
      r_shreg  <= '0;
      r_bitCnt <= '0;
      r_sout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_load) begin
      r_shreg  <= i_data;
      r_bitCnt <= BCNT_W'(1);
      r_sout   <= i_data[DATA_W-1];
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (i_shiftEn && r_busy) begin
      if (w_allDriven) begin
        r_sout <= 1'b0;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_sout   <= r_shreg[DATA_W-2];
        r_shreg  <= {r_shreg[DATA_W-2:0], 1'b0};
        r_bitCnt <= r_bitCnt + BCNT_W'(1);
      end
    end
  end

  assign o_sout    = r_sout;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_lastBit = r_busy && w_allDriven;

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: captures opcode+payload frames from MOSI,
// strobes them out on rx_data/rx_valid, and returns read data on MISO through
// a tx_valid/tx_ready handshake once a read-address frame has been seen.
// Optional feature: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err abort
// strobe port.
module spi_slave_param
  import slave_shared_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [DATA_W-1:0]    tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int FRAME_W = frameWidth(PAYLOAD_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int IDX_W   = $clog2(FRAME_W);

  STATE_e             r_state;
  STATE_e             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-1:0] r_rxData;
  logic               r_rxValid;
  logic               r_txReady;
  logic               r_rdPending;

  logic               w_active;
  logic               w_capturing;
  logic               w_lastCapture;
  logic               w_frameFull;
  logic               w_incomplete;
  logic [IDX_W-1:0]   w_capIdx;

  logic               w_shClear;
  logic               w_shLoad;
  logic               w_shShift;
  logic               w_shBusy;
  logic               w_shDone;
  logic               w_shLast;
  logic               w_miso;

  assign w_active      = (r_state == WRITE) || (r_state == READ_ADD) ||
                         (r_state == READ_DATA);
  assign w_frameFull   = (r_cnt == CNT_W'(FRAME_W));
  assign w_capturing   = w_active && !SS_n && !w_frameFull;
  assign w_lastCapture = w_capturing && (r_cnt == CNT_W'(FRAME_W - 1));
  assign w_capIdx      = IDX_W'(FRAME_W - 1 - int'(r_cnt));

  // A transfer left now is an abort if the frame or the read-out is unfinished
  assign w_incomplete  = !w_frameFull || ((r_state == READ_DATA) && !w_shDone);

  // The shifter only runs while a read-data transfer is still selected
  assign w_shClear = (r_state != READ_DATA) || SS_n;
  assign w_shLoad  = !w_shClear && r_txReady && tx_valid;
  assign w_shShift = !w_shClear;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection: direction bit and pending read pick the transfer type
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (!SS_n) w_nextState = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)             w_nextState = IDLE;
        else if (!MOSI)       w_nextState = WRITE;
        else if (!r_rdPending) w_nextState = READ_ADD;
        else                  w_nextState = READ_DATA;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Frame capture into rx_data, bit counter and completion strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxValid <= w_lastCapture;
      if (w_capturing) begin
        r_rxData[w_capIdx] <= MOSI;
        r_cnt              <= r_cnt + CNT_W'(1);
      end else if (!w_active || SS_n) begin
        r_cnt <= '0;
      end
    end
  end

  // Read handshake: arm tx_ready after a read-data frame, drop it on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txReady <= 1'b0;
    end else if (w_shClear || w_shLoad) begin
      r_txReady <= 1'b0;
    end else if (w_frameFull && !r_txReady && !w_shBusy && !w_shDone) begin
      r_txReady <= 1'b1;
    end
  end

  // Pending-read flag: set by a completed read address, cleared by a full read-out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPending <= 1'b0;
    end else if (w_lastCapture && (r_state == READ_ADD)) begin
      r_rdPending <= 1'b1;
    end else if (!w_shClear && w_shLast) begin
      r_rdPending <= 1'b0;
    end
  end

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_txShifter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_shClear),
    .i_load    (w_shLoad),
    .i_data    (tx_data),
    .i_shiftEn (w_shShift),
    .o_sout    (w_miso),
    .o_busy    (w_shBusy),
    .o_done    (w_shDone),
    .o_lastBit (w_shLast)
  );

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_frameErr;

  // One-cycle abort strobe when a transfer is deselected before it finished
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frameErr <= 1'b0;
    end else begin
      r_frameErr <= w_active && SS_n && w_incomplete;
    end
  end

  assign frame_err = r_frameErr;
`else
  logic w_unusedIncomplete;
  assign w_unusedIncomplete = w_incomplete;
`endif

  assign MISO     = w_miso;
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign tx_ready = r_txReady;

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: a default-width instance driven
// from a vector table, hand sequences and random transactions checked against
// a frame-level model, plus a wide instance (PAYLOAD_W=14, DATA_W=16).
module tb_spi_slave_param;
  import slave_shared_pkg::*;

  localparam int FW  = 10;
  localparam int DW  = 8;
  localparam int FWW = 16;
  localparam int DWW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ssN, mosi, miso, rxValid, txValid, txReady;
  logic [FW-1:0] rxData;
  logic [DW-1:0] txData;
  logic          ssW, mosiW, misoW, rxValidW, txValidW, txReadyW;
  logic [FWW-1:0] rxDataW;
  logic [DWW-1:0] txDataW;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frameErr, frameErrW;
`endif

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.PAYLOAD_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .SS_n(ssN), .MOSI(mosi), .MISO(miso),
    .rx_data(rxData), .rx_valid(rxValid), .tx_data(txData),
    .tx_valid(txValid), .tx_ready(txReady)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(frameErr)
`endif
  );

  spi_slave_param #(.PAYLOAD_W(14), .DATA_W(16)) dutWide (
    .clk(clk), .rst(rst), .SS_n(ssW), .MOSI(mosiW), .MISO(misoW),
    .rx_data(rxDataW), .rx_valid(rxValidW), .tx_data(txDataW),
    .tx_valid(txValidW), .tx_ready(txReadyW)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(frameErrW)
`endif
  );

  typedef struct {
    bit            dir;
    logic [FW-1:0] frame;
    int            abortAt;
    logic [DW-1:0] txd;
    int            txDelay;
    bit            earlyTx;
    int            cutAt;
    bit            cutByReset;
    logic [FW-1:0] expRxData;
    bit            expPulse;
    bit            expTxReady;
    bit            expErr;
  } vec_t;

  // Frame-level reference state: what rx_data should hold and whether a read is pending
  logic [FW-1:0] mRx   = '0;
  bit            mPend = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkErr(input string name, input bit exp);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    checkOutput(name, frameErr, exp);
`else
    if (exp && 1'b0) $display("[TB] %s", name);
`endif
  endtask

  function automatic vec_t mkVec(input bit dir, input logic [FW-1:0] frame, input int abortAt,
                                 input logic [DW-1:0] txd, input int txDelay, input bit earlyTx,
                                 input logic [FW-1:0] expRx, input bit expPulse,
                                 input bit expTxReady, input bit expErr);
    vec_t v;
    v.dir = dir; v.frame = frame; v.abortAt = abortAt; v.txd = txd;
    v.txDelay = txDelay; v.earlyTx = earlyTx; v.cutAt = -1; v.cutByReset = 1'b0;
    v.expRxData = expRx; v.expPulse = expPulse; v.expTxReady = expTxReady; v.expErr = expErr;
    return v;
  endfunction

  // Frame-level model: bits captured overwrite the model frame MSB-first,
  // a complete read-address arms a pending read, a finished read-out clears it
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int   nBits;
    bit   complete, isRdData, isRdAddr;
    r        = v;
    complete = (v.abortAt < 0);
    isRdData = v.dir && mPend;
    isRdAddr = v.dir && !mPend;
    nBits    = complete ? FW : v.abortAt;
    for (int i = 0; i < nBits; i++) mRx[FW-1-i] = v.frame[FW-1-i];
    r.expRxData  = mRx;
    r.expPulse   = complete;
    r.expErr     = !complete;
    r.expTxReady = complete && isRdData;
    if (complete && isRdAddr) mPend = 1'b1;
    if (r.expTxReady) begin
      if (v.cutAt < 0) mPend = 1'b0;
      else if (v.cutByReset) begin
        mPend = 1'b0;
        mRx   = '0;
      end
    end
    return r;
  endfunction

  // Runs one SS_n-framed transaction on the default instance, starting and ending idle
  task automatic applyStimulus(input vec_t v);
    int nBits;
    bit cut;
    nBits   = (v.abortAt < 0) ? FW : v.abortAt;
    txValid = v.earlyTx;
    txData  = ~v.txd;
    ssN     = 1'b0;
    mosi    = 1'b0;
    @(negedge clk);
    mosi = v.dir;
    @(negedge clk);
    for (int i = 0; i < nBits; i++) begin
      checkOutput("captureRxValid", rxValid, 0);
      checkOutput("captureTxReady", txReady, 0);
      checkOutput("captureMiso", miso, 0);
      mosi = v.frame[FW-1-i];
      @(negedge clk);
    end
    if (v.abortAt >= 0) begin
      checkOutput("abortRxValid", rxValid, 0);
      ssN = 1'b1; txValid = 1'b0;
      @(negedge clk);
      checkOutput("abortRxValidAfter", rxValid, 0);
      checkOutput("abortRxData", rxData, v.expRxData);
      checkOutput("abortTxReady", txReady, 0);
      checkErr("abortFrameErr", v.expErr);
      @(negedge clk);
      checkErr("frameErrOneCycle", 1'b0);
    end else begin
      checkOutput("rxValidPulse", rxValid, v.expPulse);
      checkOutput("rxData", rxData, v.expRxData);
      checkOutput("txReadyAtCompletion", txReady, 0);
      txValid = 1'b0;
      @(negedge clk);
      checkOutput("rxValidOneCycle", rxValid, 0);
      checkOutput("txReady", txReady, v.expTxReady);
      cut = 1'b0;
      if (v.expTxReady) begin
        for (int d = 0; d < v.txDelay; d++) begin
          @(negedge clk);
          checkOutput("txReadyHeld", txReady, 1);
          checkOutput("misoBeforeAccept", miso, 0);
        end
        txValid = 1'b1; txData = v.txd;
        @(negedge clk);
        txValid = 1'b0; txData = ~v.txd;
        checkOutput("txReadyDropsOnAccept", txReady, 0);
        checkOutput("misoMsb", miso, v.txd[DW-1]);
        for (int k = 1; k <= DW && !cut; k++) begin
          if (v.cutAt == k) begin
            cut = 1'b1;
            ssN = 1'b1;
            if (v.cutByReset) begin
              rst = 1'b1;
              #1;
              checkOutput("resetMiso", miso, 0);
              checkOutput("resetRxData", rxData, 0);
              checkOutput("resetRxValid", rxValid, 0);
              checkOutput("resetTxReady", txReady, 0);
              checkErr("resetFrameErr", 1'b0);
              @(negedge clk);
              rst = 1'b0;
            end else begin
              @(negedge clk);
              checkOutput("interruptMiso", miso, 0);
              checkOutput("interruptTxReady", txReady, 0);
              checkErr("interruptFrameErr", 1'b1);
              @(negedge clk);
            end
          end else begin
            @(negedge clk);
            checkOutput(k < DW ? "misoBit" : "misoAfterLast", miso,
                        k < DW ? v.txd[DW-1-k] : 1'b0);
          end
        end
        if (!cut) begin
          @(negedge clk);
          checkOutput("txReadyNoRearm", txReady, 0);
          checkOutput("misoHeldLow", miso, 0);
        end
      end
      if (!cut) begin
        ssN = 1'b1;
        @(negedge clk);
        checkOutput("idleMiso", miso, 0);
        checkOutput("idleTxReady", txReady, 0);
        checkOutput("idleRxValid", rxValid, 0);
        checkErr("noFrameErr", 1'b0);
      end
    end
    ssN = 1'b1; txValid = 1'b0;
  endtask

  // One transaction on the wide instance; rx_data must equal the full frame
  task automatic wideFrame(input bit dir, input logic [FWW-1:0] frame, input bit expReady,
                           input logic [DWW-1:0] txd);
    ssW = 1'b0; mosiW = 1'b0;
    @(negedge clk);
    mosiW = dir;
    @(negedge clk);
    for (int i = 0; i < FWW; i++) begin
      checkOutput("wideCaptureRxValid", rxValidW, 0);
      mosiW = frame[FWW-1-i];
      @(negedge clk);
    end
    checkOutput("wideRxValid", rxValidW, 1);
    checkOutput("wideRxData", rxDataW, frame);
    @(negedge clk);
    checkOutput("wideTxReady", txReadyW, expReady);
    if (expReady) begin
      txValidW = 1'b1; txDataW = txd;
      @(negedge clk);
      txValidW = 1'b0; txDataW = '0;
      checkOutput("wideMisoMsb", misoW, txd[DWW-1]);
      for (int k = 1; k < DWW; k++) begin
        @(negedge clk);
        checkOutput("wideMisoBit", misoW, txd[DWW-1-k]);
      end
      @(negedge clk);
      checkOutput("wideMisoAfterLast", misoW, 0);
    end
    ssW = 1'b1;
    @(negedge clk);
    checkOutput("wideIdleMiso", misoW, 0);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    rst = 1'b1;
    ssN = 1'b1; mosi = 1'b0; txData = '0; txValid = 1'b0;
    ssW = 1'b1; mosiW = 1'b0; txDataW = '0; txValidW = 1'b0;

    // dir, frame, abortAt, txd, txDelay, earlyTx, expRx, expPulse, expTxReady, expErr
    tbl[0]  = mkVec(0, 10'h0A5, -1, 8'h00, 0, 0, 10'h0A5, 1, 0, 0);
    tbl[1]  = mkVec(1, 10'h203, -1, 8'h00, 0, 0, 10'h203, 1, 0, 0);
    tbl[2]  = mkVec(1, 10'h300, -1, 8'hC3, 0, 0, 10'h300, 1, 1, 0);
    tbl[3]  = mkVec(0, 10'h3FF,  5, 8'h00, 0, 0, 10'h3E0, 0, 0, 1);
    tbl[4]  = mkVec(1, 10'h2AA, -1, 8'h00, 0, 1, 10'h2AA, 1, 0, 0);
    tbl[5]  = mkVec(1, 10'h355, -1, 8'h96, 2, 1, 10'h355, 1, 1, 0);
    tbl[6]  = mkVec(1, 10'h1FF,  0, 8'h00, 0, 0, 10'h355, 0, 0, 1);
    tbl[7]  = mkVec(0, 10'h000, -1, 8'h00, 0, 0, 10'h000, 1, 0, 0);
    tbl[8]  = mkVec(1, 10'h3FF, -1, 8'h00, 0, 0, 10'h3FF, 1, 0, 0);
    tbl[9]  = mkVec(1, 10'h0F0,  9, 8'h00, 0, 0, 10'h0F1, 0, 0, 1);
    tbl[10] = mkVec(1, 10'h123, -1, 8'h01, 1, 0, 10'h123, 1, 1, 0);
    tbl[11] = mkVec(0, 10'h2D6, -1, 8'h00, 0, 1, 10'h2D6, 1, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("resetMiso", miso, 0);
    checkOutput("resetRxData", rxData, 0);
    checkOutput("resetRxValid", rxValid, 0);
    checkOutput("resetTxReady", txReady, 0);
    checkOutput("resetWideRxData", rxDataW, 0);
    checkOutput("resetWideTxReady", txReadyW, 0);
    checkErr("resetFrameErr", 1'b0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      void'(predict(tbl[i]));
      applyStimulus(tbl[i]);
    end

    $display("[TB] interrupted read-out and reset during read-out");
    v = mkVec(1, 10'h2F0, -1, 8'h00, 0, 0, '0, 0, 0, 0);
    applyStimulus(predict(v));
    v = mkVec(1, 10'h3C0, -1, 8'hB4, 0, 0, '0, 0, 0, 0);
    v.cutAt = 3;
    applyStimulus(predict(v));
    v = mkVec(1, 10'h3C1, -1, 8'h5E, 1, 0, '0, 0, 0, 0);
    applyStimulus(predict(v));
    v = mkVec(1, 10'h2F1, -1, 8'h00, 0, 0, '0, 0, 0, 0);
    applyStimulus(predict(v));
    v = mkVec(1, 10'h3C2, -1, 8'hE7, 0, 0, '0, 0, 0, 0);
    v.cutAt = 4; v.cutByReset = 1'b1;
    applyStimulus(predict(v));
    v = mkVec(1, 10'h3C3, -1, 8'h00, 0, 0, '0, 0, 0, 0);
    applyStimulus(predict(v));

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      v = mkVec($urandom_range(0, 1), FW'($urandom), -1, DW'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 1), '0, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) v.abortAt = $urandom_range(0, FW - 1);
      if ($urandom_range(0, 5) == 0) v.cutAt = $urandom_range(1, DW - 1);
      applyStimulus(predict(v));
    end

    $display("[TB] wide instance");
    wideFrame(1'b0, 16'h3FFF, 1'b0, 16'h0000);
    wideFrame(1'b1, {OP_RD_ADDR, 14'h0001}, 1'b0, 16'h0000);
    wideFrame(1'b1, {OP_RD_DATA, 14'h0000}, 1'b1, 16'hA53C);
    wideFrame(1'b1, {OP_RD_ADDR, 14'h0002}, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front-end for the memory-backed SPI subsystem: deserialises MOSI frames of configurable width, presents them on a parallel `rx_data` bus with a one-cycle `rx_valid` strobe, and serialises read data onto MISO using a `tx_valid`/`tx_ready` handshake. It is the next-generation slave: payload and read-data widths are generic, the read address is marked pending only on a complete frame, and aborted frames can be flagged. It sits between the SPI pins and the RAM/register controller.

## Interface
- `PAYLOAD_W`, 8: payload bits per frame. `FRAME_W = PAYLOAD_W+2` is the captured width: 2 opcode bits plus payload.
- `DATA_W`, 8: read-data width shifted out on MISO.
- `clk` input 1: SPI/system clock. All sampling and driving happens on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `SS_n` input 1: slave select, active low.
- `MOSI` input 1: serial data in, MSB first.
- `MISO` output 1: serial data out, MSB first.
- `rx_data` output FRAME_W: last captured frame.
- `rx_valid` output 1: one-cycle strobe marking a complete frame.
- `tx_data` input DATA_W: read data from the controller.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: the slave is waiting for read data.
- `frame_err` output 1: one-cycle abort strobe. It exists only with the macro defined (see Configuration).

## Operation
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- **Internal `rd_pending` flag:** reset value 0.
- **IDLE:**
  - `SS_n`=0 → CHK_CMD.
  - Counters cleared, MISO←0.
- **CHK_CMD:** samples the MOSI direction bit.
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_pending`=0 → READ_ADD.
  - MOSI=1 and `rd_pending`=1 → READ_DATA.
  - `SS_n`=1 → IDLE.
- **Capture (WRITE, READ_ADD, READ_DATA):**
  - Each edge stores MOSI into `rx_data[FRAME_W-1-cnt]` and increments `cnt`.
  - Capture stops at `cnt`=FRAME_W.
- **Frame completion:**
  - On the edge capturing bit 0, `rx_valid`←1 for exactly one cycle.
  - In READ_ADD, that same edge sets `rd_pending`←1.
  - `rx_data` holds its value until the next frame's first capture.
- **READ_DATA after capture:**
  - `tx_ready`←1 on the edge after completion.
  - On the first edge with `tx_valid`&&`tx_ready`:
    - `tx_data` loads into the shifter.
    - `tx_ready`←0.
    - MISO←`tx_data[DATA_W-1]`.
  - The next DATA_W-1 edges drive the remaining bits.
  - The following edge drives MISO←0 and clears `rd_pending`.
  - `tx_valid` is ignored when `tx_ready`=0.
- **Leaving a transfer:**
  - `SS_n`=1 in any active state → IDLE on the next edge.
  - Counters, shifter and `tx_ready` are cleared.
- **Abort:**
  - An abort is `SS_n`=1 before frame completion.
  - No `rx_valid` is produced.
  - `rd_pending` is unchanged.
- **Read data interrupted:** if `SS_n` rises during read-data shifting, `rd_pending` stays 1 and the next read frame re-enters READ_DATA.
- **Counter widths:** `cnt` is $clog2(FRAME_W+1) bits; the bit counter is $clog2(DATA_W+1) bits. Neither wraps.

## Timing
- **Reset values:**
  - `MISO`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=0, `frame_err`=0.
  - State IDLE, `rd_pending`=0.
- **Registering:** all outputs are registered; there are no combinational paths from inputs.
- **Write-frame latency:**
  - `SS_n` low seen at edge 0.
  - Direction bit at edge 1.
  - Frame bits at edges 2…FRAME_W+1.
  - `rx_valid` is high in the cycle after edge FRAME_W+1.
- **Read-data latency:** MISO MSB appears on the edge that accepts `tx_valid`. The last bit is driven DATA_W-1 edges later.
- **Reset mid-operation:** `rst` asserted at any time returns to IDLE immediately with reset values. No strobe is generated.

## Configuration
- **Macro:** `SPI_SLAVE_FRAME_ERR_EN`.
- **Defined:**
  - Port `frame_err` exists.
  - It pulses 1 for one cycle on the edge entering IDLE from WRITE, READ_ADD or READ_DATA with `cnt`<FRAME_W.
  - It also pulses when READ_DATA is left with shifting incomplete.
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Structure
- **`slave_shared_pkg`:** holds the `STATE_e` enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA) and the opcode constants (2'b00 write-address, 2'b01 write-data, 2'b10 read-address, 2'b11 read-data).
- **Sub-module `spi_tx_shifter`:**
  - Parameter DATA_W.
  - Parallel load with a load strobe, MSB-first shift-out.
  - Provides a done flag and a synchronous clear.

## Test plan
- **Write frame:** defaults, `SS_n` low, MOSI 0 then 10'b00_1010_0101 → `rx_data`=10'h0A5 with one `rx_valid` pulse 11 cycles after `SS_n` is sampled low.
- **Read address then read data:**
  - Read address: MOSI 1 then 10'b10_0000_0011 → `rx_valid`, `rd_pending`=1.
  - Read data: 1 then 10'b11_0000_0000 → `tx_ready`=1.
  - `tx_valid` with `tx_data`=8'hC3 → MISO 1,1,0,0,0,0,1,1 on consecutive edges, then `rd_pending`=0.
- **Abort after 5 bits of a write:** `SS_n`=1 → IDLE, no `rx_valid`. With `SPI_SLAVE_FRAME_ERR_EN`, `frame_err` is one cycle high.
- **Early `tx_valid`:** `tx_valid` high before READ_DATA completion → ignored; data is accepted only after `tx_ready` rises.
- **Reset mid-frame:** `rst` pulse during READ_DATA shifting → all outputs 0, next read frame goes to READ_ADD.
- **Wider parameters:** PAYLOAD_W=14, DATA_W=16, write of 16'h3FFF → `rx_data` captured correctly; 16-bit read shifts 16 bits.
